// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues word fetches to
// instruction memory with a req/gnt/rvalid handshake, buffers returned words
// in a small in-order FIFO, and presents them to decode with valid/ready.
// A redirect flushes the FIFO and marks every in-flight response for discard.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   FIFO_DEPTH   buffer entries (power of two, >= 2); also the in-flight cap
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous active-high reset
//   imem_req     fetch request valid (combinational)
//   imem_addr    word-aligned fetch byte address
//   imem_gnt     request accepted this cycle
//   imem_rvalid  response valid (in grant order)
//   imem_rdata   returned instruction word
//   redirect     single-cycle control-transfer pulse
//   redirect_pc  new fetch address (low two bits ignored)
//   instr_valid  FIFO head valid
//   instr        FIFO head word, 0 when not valid
//   instr_pc     address of instr, 0 when not valid
//   instr_ready  decode accepts the head this cycle
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Control state
   logic [31:0]      fetch_pc;
   logic [31:0]      resp_pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Buffer storage: {pc, word} per entry, not reset (gated by count)
   logic [31:0] pc_mem   [FIFO_DEPTH];
   logic [31:0] word_mem [FIFO_DEPTH];

   logic [CNT_W:0] credit_used;
   logic [31:0]    redirect_tgt;
   logic           grant;
   logic           rsp;
   logic           keep;
   logic           push;
   logic           pop;

   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

   // Credits count both in-flight requests and buffered words, so a response
   // always has a slot. Registered count only: a same-cycle pop frees no credit.
   assign credit_used = {1'b0, outstanding} + {1'b0, count};
   assign imem_req    = !reset && !redirect && (credit_used < CREDITS);
   assign imem_addr   = fetch_pc;
   assign grant       = imem_req && imem_gnt;

   // A response with nothing outstanding is a protocol violation; ignoring it
   // keeps the counters from wrapping.
   assign rsp  = imem_rvalid && (outstanding != '0);
   assign keep = rsp && (discard == '0);
   assign push = keep && (count != CNT_FULL);

   assign instr_valid = (count != '0);
   assign pop         = instr_valid && instr_ready;
   assign instr       = instr_valid ? word_mem[rd_ptr] : 32'h0;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (redirect) begin
         // Everything still unreturned after this cycle belongs to the old
         // path; the response arriving now is dropped with it.
         fetch_pc    <= redirect_tgt;
         resp_pc     <= redirect_tgt;
         outstanding <= outstanding - CNT_W'(rsp);
         discard     <= outstanding - CNT_W'(rsp);
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end

         case ({grant, rsp})
            2'b10:   outstanding <= outstanding + CNT_ONE;
            2'b01:   outstanding <= outstanding - CNT_ONE;
            default: outstanding <= outstanding;
         endcase

         if (rsp && (discard != '0)) begin
            discard <= discard - CNT_ONE;
         end

         // resp_pc tracks the stream position even if a word is lost to an
         // overfull buffer, so later words keep their correct addresses.
         if (keep) begin
            resp_pc <= resp_pc + 32'd4;
         end

         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !redirect) begin
         pc_mem[wr_ptr]   <= resp_pc;
         word_mem[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Randomized bench with a scoreboard. The expected instruction stream is the
// sequence of consecutive word addresses starting at the reset PC or at the
// most recent redirect target; each address carries a fixed pseudo-random
// memory word. A memory model answers grants in order with random latency.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_ready(instr_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;
   int cyc     = 0;

   // Stimulus knobs
   int          gnt_pct    = 100;
   int          rdy_pct    = 100;
   int          lat_max    = 1;
   bit          redir_req  = 1'b0;
   logic [31:0] redir_tgt  = 32'h0;
   bit          busy_redir = 1'b0;
   bit          busy_hit   = 1'b0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];     // memory: granted, not yet returned
   logic [31:0] exp_q[$];    // scoreboard: expected pcs in program order
   logic [31:0] exp_tail;
   logic [31:0] exp_fetch;   // expected next granted fetch address
   logic [31:0] e;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 16) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] pc);
      exp_q.delete();
      exp_tail = {pc[31:2], 2'b00};
      refill();
   endtask

   // Advance one cycle and drive all inputs just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      imem_gnt    = ($urandom_range(99) < gnt_pct);
      instr_ready = ($urandom_range(99) < rdy_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      if (redir_req || (busy_redir && imem_rvalid && instr_valid && instr_ready)) begin
         if (!redir_req) busy_hit = 1'b1;
         redirect    = 1'b1;
         redirect_pc = redir_tgt;
         restart_stream(redir_tgt);
         redir_req   = 1'b0;
      end else begin
         redirect    = 1'b0;
         redirect_pc = $urandom;
      end
      refill();
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      pend.delete();
      exp_fetch   = RESET_PC;
      restart_stream(RESET_PC);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_req",   {31'b0, imem_req},    32'd0);
      check("reset_valid", {31'b0, instr_valid}, 32'd0);
      check("reset_instr", instr,                32'd0);
      check("reset_pc",    instr_pc,             32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("first_req",  {31'b0, imem_req}, 32'd1);
      check("first_addr", imem_addr,         RESET_PC);
   endtask

   // Memory grant recorder, fetch-address model and scoreboard monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (redirect) begin
            check("no_req_on_redirect", {31'b0, imem_req}, 32'd0);
            exp_fetch = {redirect_pc[31:2], 2'b00};
         end else if (imem_req && imem_gnt) begin
            check("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            pend.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, 1))});
         end
         if (instr_valid && instr_ready && !redirect) begin
            n_pops++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow: got pc %h with nothing expected", instr_pc);
            end else begin
               e = exp_q.pop_front();
               check("instr_pc", instr_pc, e);
               check("instr",    instr,    mem_word(e));
            end
         end
         if (!instr_valid) begin
            check("idle_instr", instr,    32'd0);
            check("idle_pc",    instr_pc, 32'd0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int pops_before;

      // Reset and first-fetch latency with 1-cycle memory
      gnt_pct = 100; rdy_pct = 100; lat_max = 1;
      do_reset();
      step();                       // first grant of RESET_PC
      step();                       // response returns
      @(negedge clk);
      check("lat_not_yet", {31'b0, instr_valid}, 32'd0);
      step();
      @(negedge clk);
      check("lat_valid", {31'b0, instr_valid}, 32'd1);
      check("lat_pc",    instr_pc,             RESET_PC);
      repeat (20) step();

      // Decode stall: buffer fills, requests stop, head holds
      do_reset();
      rdy_pct = 0;
      repeat (10) step();
      @(negedge clk);
      check("stall_req",   {31'b0, imem_req},    32'd0);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_pc",    instr_pc,             RESET_PC);
      check("stall_instr", instr,                mem_word(RESET_PC));
      rdy_pct = 100;
      repeat (10) step();

      // Grant withheld: request and address held
      gnt_pct = 0;
      repeat (4) step();
      repeat (3) begin
         @(negedge clk);
         check("hold_req",  {31'b0, imem_req}, 32'd1);
         check("hold_addr", imem_addr,         exp_fetch);
         step();
      end
      gnt_pct = 100;
      repeat (10) step();

      // Redirect with slow memory: stale responses must be dropped
      lat_max = 3;
      repeat (6) step();
      redir_tgt = 32'h0000_0103; redir_req = 1'b1;
      step();
      repeat (20) step();

      // Redirect with 1-cycle memory: next cycle empty and fetching new PC
      lat_max = 1;
      repeat (6) step();
      redir_tgt = 32'h0000_0103; redir_req = 1'b1;
      step();
      step();
      @(negedge clk);
      check("redir_valid", {31'b0, instr_valid}, 32'd0);
      check("redir_req",   {31'b0, imem_req},    32'd1);
      check("redir_addr",  imem_addr,            32'h0000_0100);
      repeat (10) step();

      // Redirect colliding with a response and a pop
      busy_hit = 1'b0; busy_redir = 1'b1; redir_tgt = 32'h0000_2000;
      for (int i = 0; i < 30 && !busy_hit; i++) step();
      busy_redir = 1'b0;
      check("collide_seen", {31'b0, busy_hit}, 32'd1);
      step();
      @(negedge clk);
      check("collide_valid", {31'b0, instr_valid}, 32'd0);
      repeat (12) step();

      // Address wrap past 0xFFFF_FFFC
      redir_tgt = 32'hFFFF_FFF4; redir_req = 1'b1;
      repeat (24) step();

      // Asynchronous reset mid-burst
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("async_req",   {31'b0, imem_req},    32'd0);
      check("async_valid", {31'b0, instr_valid}, 32'd0);
      do_reset();

      // Randomized traffic with random redirects
      gnt_pct = 60; rdy_pct = 70; lat_max = 3;
      pops_before = n_pops;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 3) begin
            redir_req = 1'b1;
            redir_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
         end
         busy_redir = ($urandom_range(99) < 2);
         step();
      end
      busy_redir = 1'b0;
      check("progress", {31'b0, (n_pops - pops_before) > 200}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
